pb_debounce: RTL and testbench
==============================

# pb_debounce

Push-button conditioning stage between the board's raw key pins and the push-button PIO read port. It synchronizes each asynchronous, bouncing key input into `clk` and filters it with a per-bit stability counter. It normalizes polarity and presents a clean, glitch-free, active-high "pressed" vector that the PIO input port samples directly.

## Interface

**Parameters**
- `WIDTH`, default 7: number of button channels. Must match the PIO input width.
- `DEBOUNCE_CYCLES`, default 500000: clock cycles an input must stay unchanged before it is accepted (10 ms at 50 MHz). Legal range is 2 or more.
- `ACTIVE_LOW`, default 1: 1 means a raw pin reads 0 when pressed. 0 means a raw pin reads 1 when pressed.

**Ports**
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `pb_raw`, input, `WIDTH`: raw key pins, asynchronous to `clk`.
- `pb_clean`, output, `WIDTH`: debounced level, 1 = pressed. This feeds the PIO `in_port`.
- `pb_press`, output, `WIDTH`: one-cycle press pulse. Present only when `PB_DEBOUNCE_PRESS_PULSE_EN` is defined.

## Operation

- **Polarity:** `norm = ACTIVE_LOW ? ~pb_raw : pb_raw`. All later logic is active-high.
- **Synchronizer:** a per-bit 2-flop chain, `s1` then `s2`, samples `norm`. It resets to 0, the released state.
- **Per-bit filter:** each bit holds a `stable` register (this is `pb_clean[i]`) and a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`.
  - If `s2 == stable`: `cnt` is set to 0.
  - If `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` is incremented.
  - If `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable` takes `s2` and `cnt` is set to 0.
- **Glitch rejection:** any return of `s2` to `stable` before the count completes clears `cnt`. Pulses shorter than `DEBOUNCE_CYCLES` never reach `pb_clean`.
- **No wrap:** the counter never passes `DEBOUNCE_CYCLES-1`, so it cannot wrap.
- **Independent bits:** bits are fully independent. Simultaneous changes on several bits each complete on their own schedule.
- **Press and release are symmetric:** both edges are filtered identically.
- **Reset values:** every `s1`, `s2`, `cnt` and `stable` is 0. `pb_clean` = 0. `pb_press` = 0.
- **Reset mid-operation:** reset asserted mid-count discards the count. After reset is released, a still-pressed key is reported only after a full `DEBOUNCE_CYCLES` interval.

## Timing

- **Latency:** a clean step on `pb_raw[i]`, set up before clock edge 1, appears on `pb_clean[i]` after edge `DEBOUNCE_CYCLES+2`. That is 2 edges for the synchronizer plus `DEBOUNCE_CYCLES` edges for the filter.
- **Bouncing input:** latency is measured from the last bounce transition seen by `s2`.
- **Outputs:** `pb_clean` is registered with no combinational path from `pb_raw`. It changes at most once per `DEBOUNCE_CYCLES` cycles per bit.
- **No handshake:** the PIO samples `pb_clean` on every cycle.
- **Press pulse:** `pb_press[i]` is high for exactly the one cycle after the edge on which `stable[i]` goes 0→1. It is registered and never fires on release.

## Configuration

- **`PB_DEBOUNCE_PRESS_PULSE_EN` defined:**
  - Adds a per-bit `stable_q` delay register.
  - Adds the `pb_press` port, computed as `stable & ~stable_q`, registered.
  - `stable_q` resets to 0, so reset never produces a pulse.
- **`PB_DEBOUNCE_PRESS_PULSE_EN` undefined:**
  - The `pb_press` port and its logic are absent.
  - `pb_clean` behaviour is identical in both builds.

## Structure

- **Shared package `pb_debounce_pkg`:**
  - `PB_DEBOUNCE_CYCLES_DEFAULT` = 500000.
  - `PB_WIDTH_DEFAULT` = 7.
  - A counter-width function returning `$clog2(DEBOUNCE_CYCLES)`, minimum 1.
- **Sub-module `pb_debounce_bit`:**
  - Holds one channel: synchronizer, counter and `stable`, plus the optional press pulse.
  - The top level instantiates it `WIDTH` times in a generate loop and does the polarity normalization.

## Test plan

All scenarios run with `DEBOUNCE_CYCLES=4`, `WIDTH=7`, `ACTIVE_LOW=1`.

1. **Reset:** hold `pb_raw=7'h7F` through reset and 20 cycles → `pb_clean=7'h00` and `pb_press=7'h00` throughout.
2. **Clean press and release:** step `pb_raw` 7'h7F→7'h7E and hold → `pb_clean=7'h01` after exactly 6 edges, and `pb_press[0]` is high for one cycle. Release back to 7'h7F → `pb_clean=7'h00` 6 edges later, with no pulse.
3. **Glitch:** drive bit 0 low for 3 cycles, then high → `pb_clean` stays 7'h00 and `pb_press` never fires.
4. **Bounce:** toggle bit 2 every cycle for 9 cycles, then hold low → a single 0→1 on `pb_clean[2]`, 6 edges after the last toggle, with exactly one `pb_press[2]` pulse.
5. **Simultaneous bits:** press bits 0 and 6 on the same cycle and bit 3 two cycles later → `pb_clean` goes 7'h41, then 7'h49 two cycles after that. Bits 0 and 6 switch on the same edge.
6. **Reset mid-count:** hold bit 1 pressed and assert `reset_n` low after 3 filter cycles, then release reset with bit 1 still pressed → `pb_clean[1]=0` during reset, then 1 exactly 6 edges after reset deassertion.

Source files
------------

// File: rtl/pb_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pb_debounce_pkg
//  Description : Shared defaults and helpers for the push-button debouncer.
//                Holds the default channel count, the default filter length,
//                and the stability-counter width function used by every
//                channel.
//  Config      : PB_DEBOUNCE_PRESS_PULSE_EN (optional press-pulse output,
//                consumed by pb_debounce_if / pb_debounce_bit / pb_debounce)
//  Revision    : 1.0 - initial release
// ============================================================================
package pb_debounce_pkg;

    localparam int unsigned PB_DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int unsigned PB_WIDTH_DEFAULT           = 7;

    // Width of the per-bit stability counter. The counter only has to reach
    // DEBOUNCE_CYCLES-1, so $clog2(DEBOUNCE_CYCLES) bits are enough; never
    // return zero so a vector declaration is always legal.
    function automatic int unsigned pb_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : pb_debounce_pkg
`default_nettype wire

// File: rtl/pb_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : pb_debounce_if
//  Description : Board-side push-button bundle. Groups the raw key pins with
//                the conditioned outputs read by the PIO.
//  Signals     : pb_raw   - raw key pins (asynchronous, board polarity)
//                pb_clean - debounced level, 1 = pressed
//                pb_press - one-cycle press pulse (only with
//                           PB_DEBOUNCE_PRESS_PULSE_EN defined)
//  Modports    : master - board / PIO side (drives pb_raw, reads results)
//                slave  - debouncer side
//  Config      : PB_DEBOUNCE_PRESS_PULSE_EN adds pb_press
//  Revision    : 1.0 - initial release
// ============================================================================
interface pb_debounce_if
    import pb_debounce_pkg::*;
#(
    parameter int unsigned WIDTH = PB_WIDTH_DEFAULT
);
    logic [WIDTH-1:0] pb_raw;
    logic [WIDTH-1:0] pb_clean;
`ifdef PB_DEBOUNCE_PRESS_PULSE_EN
    logic [WIDTH-1:0] pb_press;

    modport master (output pb_raw, input  pb_clean, input  pb_press);
    modport slave  (input  pb_raw, output pb_clean, output pb_press);
`else
    modport master (output pb_raw, input  pb_clean);
    modport slave  (input  pb_raw, output pb_clean);
`endif
endinterface : pb_debounce_if
`default_nettype wire

// File: rtl/pb_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : pb_debounce_bit
//  Description : One debounced channel. A two-flop synchronizer feeds a
//                stability counter; the accepted level only changes after the
//                synchronized input has disagreed with it for
//                DEBOUNCE_CYCLES consecutive clocks.
//  Ports       : clk      - system clock
//                reset_n  - asynchronous active-low reset
//                i_norm   - raw input already normalized to 1 = pressed
//                o_clean  - accepted (debounced) level
//                o_press  - one-cycle pulse on a 0->1 of o_clean
//                           (only with PB_DEBOUNCE_PRESS_PULSE_EN defined)
//  Config      : PB_DEBOUNCE_PRESS_PULSE_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_debounce_bit
    import pb_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_norm,
    output logic      o_clean
`ifdef PB_DEBOUNCE_PRESS_PULSE_EN
    ,
    output logic      o_press
`endif
);

    localparam int unsigned          c_CNT_W   = pb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE = c_CNT_W'(1);

    logic               r_s1;
    logic               r_s2;
    logic               r_stable;
    logic [c_CNT_W-1:0] r_cnt;

    // Synchronizer resets to 0 (released) so a key held through reset is not
    // seen until the full filter interval has elapsed after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_norm;
            r_s2 <= r_s1;
        end
    end

    // Any agreement with the accepted level restarts the count, so only an
    // uninterrupted run of DEBOUNCE_CYCLES disagreeing samples is accepted.
    // The counter stops at c_CNT_MAX and is cleared on acceptance, so it
    // can never wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_s2 == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + c_CNT_ONE;
        end
    end

    assign o_clean = r_stable;

`ifdef PB_DEBOUNCE_PRESS_PULSE_EN
    logic r_stable_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_q <= 1'b0;
        end else begin
            r_stable_q <= r_stable;
        end
    end

    // Both operands are flops, so the pulse has no path from the pins. It is
    // high exactly in the cycle where r_stable has just risen and r_stable_q
    // still holds the old 0; releases (1->0) never produce it.
    assign o_press = r_stable & ~r_stable_q;
`endif

endmodule : pb_debounce_bit
`default_nettype wire

// File: rtl/pb_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : pb_debounce
//  Description : Push-button conditioning stage between the raw key pins and
//                the PIO read port. Normalizes polarity to active-high and
//                debounces every channel independently.
//  Parameters  : WIDTH           - number of button channels
//                DEBOUNCE_CYCLES - clocks an input must be steady (>= 2)
//                ACTIVE_LOW      - 1: pin reads 0 when pressed
//  Ports       : clk     - system clock
//                reset_n - asynchronous active-low reset
//                bus     - pb_debounce_if.slave (pb_raw in, pb_clean out,
//                          pb_press out when the pulse option is built)
//  Config      : PB_DEBOUNCE_PRESS_PULSE_EN - adds the pb_press pulse vector
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_debounce
    import pb_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = PB_WIDTH_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    pb_debounce_if.slave  bus
);

    logic [WIDTH-1:0] w_norm;
    logic [WIDTH-1:0] w_clean;
`ifdef PB_DEBOUNCE_PRESS_PULSE_EN
    logic [WIDTH-1:0] w_press;
`endif

    // Everything downstream of this point is active-high (1 = pressed).
    assign w_norm = ACTIVE_LOW ? ~bus.pb_raw : bus.pb_raw;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        pb_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .i_norm  (w_norm[gi]),
            .o_clean (w_clean[gi])
`ifdef PB_DEBOUNCE_PRESS_PULSE_EN
            ,
            .o_press (w_press[gi])
`endif
        );
    end

    assign bus.pb_clean = w_clean;
`ifdef PB_DEBOUNCE_PRESS_PULSE_EN
    assign bus.pb_press = w_press;
`endif

endmodule : pb_debounce
`default_nettype wire

// File: tb/tb_pb_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb_debounce
//  Description : Self-checking bench for pb_debounce (WIDTH=7,
//                DEBOUNCE_CYCLES=4, ACTIVE_LOW=1). A driver applies directed
//                and random pin patterns and pushes the reference model's
//                expected outputs into a scoreboard queue; a monitor pops and
//                compares once per clock.
//  Config      : PB_DEBOUNCE_PRESS_PULSE_EN also checks pb_press
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_debounce;

    localparam int W = 7;
    localparam int D = 4;

    typedef struct packed {
        logic [W-1:0] clean;
        logic [W-1:0] press;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t sb[$];

    pb_debounce_if #(.WIDTH(W)) bus ();

    pb_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A level is accepted once the last D synchronized samples all differ
    // from it and at least D edges have passed since it was last accepted
    // (or since reset). The synchronizer is a pure 2-sample delay.
    logic [W-1:0] m_s1 = '0;
    logic [W-1:0] m_s2 = '0;
    logic [W-1:0] m_stable = '0;
    logic [W-1:0] m_hist[$];
    int           m_edge = 0;
    int           m_last_flip[W];

    task automatic model_step(input logic [W-1:0] raw, input logic rn);
        logic [W-1:0] samp;
        logic [W-1:0] rose;
        exp_t         e;
        bit           all_diff;
        m_edge++;
        rose = '0;
        if (!rn) begin
            m_s1 = '0;
            m_s2 = '0;
            m_stable = '0;
            m_hist.delete();
            for (int i = 0; i < W; i++) m_last_flip[i] = m_edge;
        end else begin
            samp = m_s2;
            m_s2 = m_s1;
            m_s1 = ~raw;
            m_hist.push_back(samp);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            for (int i = 0; i < W; i++) begin
                if (m_hist.size() == D && (m_edge - m_last_flip[i]) >= D) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < D; j++)
                        if (m_hist[j][i] == m_stable[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_stable[i]    = ~m_stable[i];
                        m_last_flip[i] = m_edge;
                        if (m_stable[i]) rose[i] = 1'b1;
                    end
                end
            end
        end
        e.clean = m_stable;
        e.press = rose;
        sb.push_back(e);
    endtask

    // ---------------- driver helpers ----------------
    // Called at a falling edge: apply inputs, let one rising edge happen,
    // record the model's expectation, return at the next falling edge.
    task automatic cycle(input logic [W-1:0] raw, input logic rn);
        bus.pb_raw = raw;
        reset_n    = rn;
        @(posedge clk);
        #1;
        model_step(raw, rn);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_clean", bus.pb_clean, e.clean);
`ifdef PB_DEBOUNCE_PRESS_PULSE_EN
                check("sb_press", bus.pb_press, e.press);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] raw;
        int           rst_left;
        bus.pb_raw = '1;
        for (int i = 0; i < W; i++) m_last_flip[i] = 0;
        @(negedge clk);

        // 1: reset held with all keys released
        for (int k = 0; k < 20; k++) begin
            cycle(7'h7F, 1'b0);
            check("reset_clean", bus.pb_clean, 7'h00);
        end
        for (int k = 0; k < 4; k++) cycle(7'h7F, 1'b1);

        // 2: clean press / release on bit 0
        for (int k = 0; k < 5; k++) cycle(7'h7E, 1'b1);
        check("press_before_6", bus.pb_clean, 7'h00);
        cycle(7'h7E, 1'b1);
        check("press_at_6", bus.pb_clean, 7'h01);
`ifdef PB_DEBOUNCE_PRESS_PULSE_EN
        check("press_pulse", bus.pb_press, 7'h01);
`endif
        for (int k = 0; k < 4; k++) cycle(7'h7E, 1'b1);
        for (int k = 0; k < 5; k++) cycle(7'h7F, 1'b1);
        check("release_before_6", bus.pb_clean, 7'h01);
        cycle(7'h7F, 1'b1);
        check("release_at_6", bus.pb_clean, 7'h00);
        for (int k = 0; k < 4; k++) cycle(7'h7F, 1'b1);

        // 3: three-cycle glitch on bit 0 is rejected
        for (int k = 0; k < 3; k++) cycle(7'h7E, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cycle(7'h7F, 1'b1);
            check("glitch", bus.pb_clean, 7'h00);
        end

        // 4: bit 2 bounces for 9 cycles, then held pressed
        for (int k = 0; k < 9; k++) cycle((k % 2 == 0) ? 7'h7B : 7'h7F, 1'b1);
        for (int k = 0; k < 4; k++) cycle(7'h7B, 1'b1);
        check("bounce_before_6", bus.pb_clean, 7'h00);
        cycle(7'h7B, 1'b1);
        check("bounce_at_6", bus.pb_clean, 7'h04);
        for (int k = 0; k < 10; k++) cycle(7'h7F, 1'b1);

        // 5: bits 0 and 6 together, bit 3 two cycles later
        for (int k = 0; k < 2; k++) cycle(7'h3E, 1'b1);
        for (int k = 0; k < 3; k++) cycle(7'h36, 1'b1);
        check("simul_before", bus.pb_clean, 7'h00);
        cycle(7'h36, 1'b1);
        check("simul_0_6", bus.pb_clean, 7'h41);
        cycle(7'h36, 1'b1);
        check("simul_hold", bus.pb_clean, 7'h41);
        cycle(7'h36, 1'b1);
        check("simul_3", bus.pb_clean, 7'h49);
        for (int k = 0; k < 10; k++) cycle(7'h7F, 1'b1);
        check("simul_release", bus.pb_clean, 7'h00);

        // 6: reset in the middle of a count on bit 1
        for (int k = 0; k < 5; k++) cycle(7'h7D, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(7'h7D, 1'b0);
            check("midrst_in_reset", bus.pb_clean, 7'h00);
        end
        for (int k = 0; k < 5; k++) cycle(7'h7D, 1'b1);
        check("midrst_before_6", bus.pb_clean, 7'h00);
        cycle(7'h7D, 1'b1);
        check("midrst_at_6", bus.pb_clean, 7'h02);
        for (int k = 0; k < 10; k++) cycle(7'h7F, 1'b1);

        // Random: sparse per-bit toggles with occasional resets
        raw = 7'h7F;
        rst_left = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
            if (rst_left == 0 && $urandom_range(0, 299) == 0)
                rst_left = $urandom_range(1, 3);
            if (rst_left > 0) begin
                cycle(raw, 1'b0);
                rst_left--;
            end else begin
                cycle(raw, 1'b1);
            end
        end

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pb_debounce
`default_nettype wire
